// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC owner, in-order imem requester, prefetch FIFO
// feeding decode over valid/ready, with redirect squash of wrong-path fetches.
// Optional performance counters are built when IF_PERF_EN is defined.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_bubble_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     filled_cnt_q, filled_cnt_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     stale_q, stale_d;

    logic [63:0]       slot_pc_q    [DEPTH];
    logic [31:0]       slot_instr_q [DEPTH];
    logic [DEPTH-1:0]  slot_filled_q;

    logic              pop;
    logic              accept;
    logic              rsp_fill;
    logic [SW-1:0]     demand;
    logic [CW-1:0]     outst_left;

    assign if_valid       = slot_filled_q[head_q];
    assign if_instruction = slot_instr_q[head_q];
    assign if_pc          = slot_pc_q[head_q];
    assign imem_req_addr  = fetch_pc_q;

    // Next-state, request issue and FIFO bookkeeping.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        head_d         = head_q;
        tail_d         = tail_q;
        fill_d         = fill_q;
        filled_cnt_d   = filled_cnt_q;
        outst_d        = outst_q;
        stale_d        = stale_q;
        imem_req_valid = 1'b0;

        pop      = if_valid && if_ready;
        rsp_fill = imem_rsp_valid && (state_q == ST_FETCH) && !redirect_valid;
        // A slot popped this cycle is free at the same edge, so it counts as credit.
        demand   = SW'(outst_q) + SW'(filled_cnt_q) - SW'(pop);
        outst_left = outst_q - CW'(imem_rsp_valid);

        if (state_q == ST_FETCH) begin
            imem_req_valid = (demand < SW'(DEPTH)) && !redirect_valid;
        end
        accept = imem_req_valid && imem_req_ready;

        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid && (outst_left != '0)) begin
                    state_d = ST_FLUSH;
                    stale_d = outst_left;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid && (stale_q != '0)) begin
                    stale_d = stale_q - CW'(1);
                    if (stale_q == CW'(1)) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        if (redirect_valid) begin
            // Every in-flight request becomes stale; only stale_q tracks them now.
            fetch_pc_d   = redirect_pc & ~64'h3;
            head_d       = '0;
            tail_d       = '0;
            fill_d       = '0;
            filled_cnt_d = '0;
            outst_d      = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                tail_d     = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (rsp_fill) begin
                fill_d = fill_q + PW'(1);
            end
            filled_cnt_d = filled_cnt_q + CW'(rsp_fill) - CW'(pop);
            outst_d      = outst_q + CW'(accept) - CW'(rsp_fill);
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RST;
            fetch_pc_q   <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            filled_cnt_q <= '0;
            outst_q      <= '0;
            stale_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            filled_cnt_q <= filled_cnt_d;
            outst_q      <= outst_d;
            stale_q      <= stale_d;
        end
    end

    // Prefetch slots: allocate on accept, fill on response, clear on pop/redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_pc_q     <= '{default: '0};
            slot_instr_q  <= '{default: '0};
            slot_filled_q <= '0;
        end else if (redirect_valid) begin
            slot_filled_q <= '0;
        end else begin
            if (pop) begin
                slot_filled_q[head_q] <= 1'b0;
            end
            if (rsp_fill) begin
                slot_filled_q[fill_q] <= 1'b1;
                slot_instr_q[fill_q]  <= imem_rsp_data;
            end
            if (accept) begin
                slot_pc_q[tail_q]     <= fetch_pc_q;
                slot_filled_q[tail_q] <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    assign perf_fetch_count  = perf_fetch_q;
    assign perf_bubble_count = perf_bubble_q;

    // Transfer and empty-cycle counters; both wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((state_q != ST_RST) && !if_valid) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage with a fixed-latency
// in-order memory model and per-cycle directed vectors.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_bubble_count;
`endif

    instruction_fetch_stage #(
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_count  (perf_fetch_count),
        .perf_bubble_count (perf_bubble_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [63:0] rpc;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [63:0] e_pc;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [63:0] acc_log[$];
    vec_t        tbl[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          lat    = 1;
    int          cyc    = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0013;
    endfunction

    function automatic vec_t mk(input int rdy, input int redir, input logic [63:0] rpc,
                                input int rv, input logic [63:0] addr,
                                input int iv, input logic [63:0] pc);
        vec_t v;
        v.rdy    = (rdy != 0);
        v.redir  = (redir != 0);
        v.rpc    = rpc;
        v.e_rv   = (rv != 0);
        v.e_addr = addr;
        v.e_iv   = (iv != 0);
        v.e_pc   = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one clock: log an accepted request, then present any due response.
    task automatic edge_step();
        logic        acc;
        logic [63:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) begin
            mq.push_back('{addr: a, due: cyc - 1 + lat});
            acc_log.push_back(a);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        if_ready       = v.rdy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        #1;
        chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'(v.e_rv));
        chk({tag, ".req_addr"}, imem_req_addr, v.e_addr);
        chk({tag, ".if_valid"}, 64'(if_valid), 64'(v.e_iv));
        if (v.e_iv) begin
            chk({tag, ".if_pc"}, if_pc, v.e_pc);
            chk({tag, ".if_instr"}, 64'(if_instruction), 64'(instr_of(v.e_pc)));
        end
        edge_step();
    endtask

    task automatic do_reset(input int new_lat);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mq.delete();
        acc_log.delete();
        lat = new_lat;
        cyc = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst.req_addr", imem_req_addr, 64'h0);
        chk("rst.if_valid", 64'(if_valid), 64'h0);
        chk("rst.if_pc", if_pc, 64'h0);
        chk("rst.if_instr", 64'(if_instruction), 64'h0);
`ifdef IF_PERF_EN
        chk("rst.perf_fetch", 64'(perf_fetch_count), 64'h0);
        chk("rst.perf_bubble", 64'(perf_bubble_count), 64'h0);
`endif
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n40;

        // Streaming from reset, then a 5-cycle decode stall and resume.
        do_reset(1);
        tbl.push_back(mk(1,0,64'h0, 0,64'h0,  0,64'h0));   // RST
        tbl.push_back(mk(1,0,64'h0, 1,64'h0,  0,64'h0));   // first FETCH cycle
        tbl.push_back(mk(1,0,64'h0, 1,64'h4,  0,64'h0));
        tbl.push_back(mk(1,0,64'h0, 1,64'h8,  1,64'h0));
        tbl.push_back(mk(1,0,64'h0, 1,64'hC,  1,64'h4));
        tbl.push_back(mk(1,0,64'h0, 1,64'h10, 1,64'h8));
        tbl.push_back(mk(1,0,64'h0, 1,64'h14, 1,64'hC));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,0,64'h0, 0,64'h18, 1,64'h10));
        tbl.push_back(mk(1,0,64'h0, 1,64'h18, 1,64'h10));
        tbl.push_back(mk(1,0,64'h0, 1,64'h1C, 1,64'h14));
        tbl.push_back(mk(1,0,64'h0, 1,64'h20, 1,64'h18));
        tbl.push_back(mk(1,0,64'h0, 1,64'h24, 1,64'h1C));
        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("stream[%0d]", i), tbl[i]);
        chk("stream.req_count", 64'(acc_log.size()), 64'd10);

        // Asynchronous reset mid-stream clears outputs immediately.
        reset = 1'b0;
        #1;
        chk("async_rst.if_valid", 64'(if_valid), 64'h0);
        chk("async_rst.req_valid", 64'(imem_req_valid), 64'h0);
        chk("async_rst.req_addr", imem_req_addr, 64'h0);
        chk("async_rst.if_pc", if_pc, 64'h0);

        // Latency-3 memory, redirect to 0x100 with two requests in flight.
        do_reset(3);
        run_vec("flush[R]", mk(1,0,64'h0,   0,64'h0,   0,64'h0));
        run_vec("flush[0]", mk(1,0,64'h0,   1,64'h0,   0,64'h0));
        run_vec("flush[1]", mk(1,0,64'h0,   1,64'h4,   0,64'h0));
        run_vec("flush[2]", mk(1,1,64'h100, 0,64'h8,   0,64'h0));
        run_vec("flush[3]", mk(1,0,64'h0,   0,64'h100, 0,64'h0));
        run_vec("flush[4]", mk(1,0,64'h0,   0,64'h100, 0,64'h0));
        run_vec("flush[5]", mk(1,0,64'h0,   1,64'h100, 0,64'h0));
        run_vec("flush[6]", mk(1,0,64'h0,   1,64'h104, 0,64'h0));
        run_vec("flush[7]", mk(1,0,64'h0,   0,64'h108, 0,64'h0));
        run_vec("flush[8]", mk(1,0,64'h0,   0,64'h108, 0,64'h0));
        run_vec("flush[9]", mk(1,0,64'h0,   1,64'h108, 1,64'h100));
        run_vec("flush[10]", mk(1,0,64'h0,  1,64'h10C, 1,64'h104));
        run_vec("flush[11]", mk(1,0,64'h0,  0,64'h110, 0,64'h0));
        chk("flush.req_count", 64'(acc_log.size()), 64'd6);
        chk("flush.third_req", acc_log[2], 64'h100);

        // Redirect to 0x203 with nothing outstanding and a full FIFO.
        do_reset(1);
        run_vec("redir[R]", mk(0,0,64'h0,   0,64'h0,   0,64'h0));
        run_vec("redir[0]", mk(0,0,64'h0,   1,64'h0,   0,64'h0));
        run_vec("redir[1]", mk(0,0,64'h0,   1,64'h4,   0,64'h0));
        run_vec("redir[2]", mk(0,0,64'h0,   0,64'h8,   1,64'h0));
        run_vec("redir[3]", mk(0,1,64'h203, 0,64'h8,   1,64'h0));
        run_vec("redir[4]", mk(1,0,64'h0,   1,64'h200, 0,64'h0));
        run_vec("redir[5]", mk(1,0,64'h0,   1,64'h204, 0,64'h0));
        run_vec("redir[6]", mk(1,0,64'h0,   1,64'h208, 1,64'h200));

        // Two redirects while flushing: only the second target is fetched.
        do_reset(3);
        run_vec("dbl[R]", mk(1,0,64'h0,  0,64'h0,  0,64'h0));
        run_vec("dbl[0]", mk(1,0,64'h0,  1,64'h0,  0,64'h0));
        run_vec("dbl[1]", mk(1,0,64'h0,  1,64'h4,  0,64'h0));
        run_vec("dbl[2]", mk(1,1,64'h40, 0,64'h8,  0,64'h0));
        run_vec("dbl[3]", mk(1,1,64'h80, 0,64'h40, 0,64'h0));
        run_vec("dbl[4]", mk(1,0,64'h0,  0,64'h80, 0,64'h0));
        run_vec("dbl[5]", mk(1,0,64'h0,  1,64'h80, 0,64'h0));
        run_vec("dbl[6]", mk(1,0,64'h0,  1,64'h84, 0,64'h0));
        run_vec("dbl[7]", mk(1,0,64'h0,  0,64'h88, 0,64'h0));
        run_vec("dbl[8]", mk(1,0,64'h0,  0,64'h88, 0,64'h0));
        run_vec("dbl[9]", mk(1,0,64'h0,  1,64'h88, 1,64'h80));
        n40 = 0;
        foreach (acc_log[i]) if (acc_log[i] == 64'h40) n40++;
        chk("dbl.no_0x40_req", 64'(n40), 64'h0);

        // PC wrap at the top of the address space; 3 empty cycles then 10 transfers.
        do_reset(1);
        run_vec("wrap[R]", mk(1,0,64'h0, 0,64'h0, 0,64'h0));
        run_vec("wrap[0]", mk(1,1,64'hFFFF_FFFF_FFFF_FFFC, 0,64'h0, 0,64'h0));
        run_vec("wrap[1]", mk(1,0,64'h0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,64'h0));
        run_vec("wrap[2]", mk(1,0,64'h0, 1,64'h0, 0,64'h0));
        run_vec("wrap[3]", mk(1,0,64'h0, 1,64'h4, 1,64'hFFFF_FFFF_FFFF_FFFC));
        for (int k = 4; k <= 12; k++)
            run_vec($sformatf("wrap[%0d]", k), mk(1,0,64'h0, 1,64'(4*(k-2)), 1,64'(4*(k-4))));
        #1;
        chk("wrap.if_pc_end", if_pc, 64'h24);
`ifdef IF_PERF_EN
        chk("perf.fetch_count", 64'(perf_fetch_count), 64'd10);
        chk("perf.bubble_count", 64'(perf_bubble_count), 64'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- Pipelined instruction-fetch front end. Sits directly upstream of the decode stage (instruction parser, control unit, immediate extractor).
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions, each with its PC, in a small prefetch FIFO.
- Hands instructions to decode over a valid/ready handshake and squashes wrong-path fetches on a branch/jump redirect.

## Interface
Parameters:
- RESET_PC, 64'h0, first fetch address after reset
- DEPTH, 2, prefetch FIFO entries; power of two, ≥2

Ports:
- clock  in  1  rising-edge clock; the block has one clock
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address, [1:0] always 0
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after request accept, never back-pressured
- imem_rsp_data  in  32  returned instruction
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  64  new fetch address; bits [1:0] ignored (forced 0)
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_instruction  out  32  head instruction
- if_pc  out  64  head PC
- perf_fetch_count  out  32  only with IF_PERF_EN
- perf_bubble_count  out  32  only with IF_PERF_EN

## Operation
Registered state:
- fetch_pc
- FIFO: DEPTH × {pc, instr, filled}
- outstanding count
- stale count
- FSM state

Request issue:
- Credit rule: a request issues only when outstanding + FIFO occupancy < DEPTH. Responses therefore never overflow the FIFO.
- In FETCH, imem_req_valid = credit available && !redirect_valid.
- A request is accepted when imem_req_valid && imem_req_ready.
- On accept: allocate the FIFO tail slot with pc = fetch_pc, then fetch_pc += 4 (mod 2^64, wraps silently).

Responses:
- Each response fills the oldest unfilled slot in order.
- In FLUSH, responses are discarded and stale count decrements.

Decode handshake:
- if_valid = head slot filled.
- Transfer occurs when if_valid && if_ready; the head pops.
- if_instruction and if_pc hold stable while if_valid && !if_ready.

FSM:
- RST → FETCH on the first edge after reset deasserts.
- FETCH → FLUSH on redirect_valid when outstanding, excluding a response arriving in the same cycle, is > 0. Stale count is loaded with that value.
- FETCH stays in FETCH on redirect_valid when outstanding = 0.
- FLUSH → FETCH when stale count reaches 0 (last stale response seen).
- No requests are issued in FLUSH.
- A redirect while in FLUSH updates fetch_pc only; stale count is unchanged.

Redirect effects (any state):
- fetch_pc ← {redirect_pc[63:2], 2'b00}.
- All FIFO entries are cleared.
- If the head transfers in the redirect cycle, that transfer counts; decode squashes it.
- A response arriving in the redirect cycle is discarded.

## Timing
- Reset values: fetch_pc = RESET_PC, FIFO empty, counts 0, state RST, imem_req_valid = 0, if_valid = 0, imem_req_addr = RESET_PC, if_instruction = 0, if_pc = 0, perf counters 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). In-flight responses after reset are the memory's responsibility.
- The first request is presented in the first cycle after reset deasserts plus one edge (state FETCH).
- Response in cycle N → if_valid in cycle N+1. Fetch-to-decode latency = memory latency + 1.
- Redirect sampled at edge k, no outstanding: request for redirect_pc presented in cycle k+1.
- Redirect with outstanding requests: the new request is presented the cycle after the last stale response.
- Sustained throughput: 1 instruction/cycle with single-cycle memory and if_ready held high.

## Configuration
- IF_PERF_EN defined:
  - perf_fetch_count increments on each decode transfer.
  - perf_bubble_count increments every FETCH/FLUSH cycle with if_valid = 0.
  - Both are 32-bit, wrap, and reset to 0.
- IF_PERF_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset release, RESET_PC = 0, 1-cycle memory, if_ready = 1: if_pc sequence 0, 4, 8, 12 on consecutive cycles; if_valid first high 2 cycles after the FETCH entry.
- Hold if_ready = 0 for 5 cycles: at most DEPTH = 2 requests plus outstanding; no more requests issue; if_instruction/if_pc stable; after release, transfers resume in order with no loss or duplication.
- Memory latency 3, two requests outstanding, redirect_pc = 0x100: both stale responses dropped; next request addr = 0x100 the cycle after the second stale response; next if_pc = 0x100.
- Redirect with redirect_pc = 0x203 and no outstanding: imem_req_addr = 0x200 next cycle; FIFO cleared; if_valid low that cycle.
- Two redirects (0x40, then 0x80) while in FLUSH: only 0x80 fetched; 0x40 never requested.
- Fetch at 0xFFFF_FFFF_FFFF_FFFC: next request addr = 0; with IF_PERF_EN, 10 transfers plus 3 empty cycles give perf_fetch_count = 10, perf_bubble_count = 3.
